// File: rtl/pulse_train_monitor.sv
// pulse_train_monitor: counts armed pulse bursts, measures width/gap, closes on idle timeout (optional PULSE_MON_SYNC_EN input synchronizer)
module pulse_train_monitor #(
  parameter int CNT_W   = 8,
  parameter int WID_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             pulse_in,
  input  logic             arm_i,
  input  logic [CNT_W-1:0] expected_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             match_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic [WID_W-1:0] width_o,
  output logic [WID_W-1:0] gap_o
);
  typedef enum logic [2:0] {IDLE, WAIT_EDGE, HIGH, LOW, DONE} state_t;
  localparam logic [WID_W-1:0] TO_M1 = WID_W'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic s_q, s_d, sd_q, sd_d, rise, fall;
  logic ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, exp_q, exp_d;
  logic [WID_W-1:0] wid_q, wid_d, gap_q, gap_d, wc_q, wc_d, lc_q, lc_d;
`ifdef PULSE_MON_SYNC_EN
  logic [1:0] sy_q, sy_d;
  // two-flop synchronizer ahead of the sample flop for asynchronous sources
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) sy_q <= '0;
    else sy_q <= sy_d;
  // sample chain input taken from the synchronizer output
  always_comb begin
    sy_d = {sy_q[0], pulse_in};
    s_d  = sy_q[1];
    sd_d = s_q;
  end
`else
  // sample chain input taken directly from the synchronous pulse input
  always_comb begin
    s_d  = pulse_in;
    sd_d = s_q;
  end
`endif
  assign rise = s_q & ~sd_q;
  assign fall = ~s_q & sd_q;
  // state and datapath registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      sd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      exp_q   <= '0;
      wid_q   <= '0;
      gap_q   <= '0;
      wc_q    <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sd_q    <= sd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      wid_q   <= wid_d;
      gap_q   <= gap_d;
      wc_q    <= wc_d;
      lc_q    <= lc_d;
    end
  // next state: arm always restarts; the low run closes the burst once it reaches TIMEOUT
  always_comb begin
    state_d = state_q;
    if (arm_i) state_d = WAIT_EDGE;
    else
      case (state_q)
        WAIT_EDGE: state_d = rise ? HIGH : WAIT_EDGE;
        HIGH:      state_d = fall ? (TIMEOUT == 1 ? DONE : LOW) : HIGH;
        LOW:       state_d = rise ? HIGH : (lc_q == TO_M1 ? DONE : LOW);
        default:   state_d = state_q;
      endcase
  end
  // measurement datapath: counting on rises, width on fall, low run while in LOW
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    exp_d = exp_q;
    wid_d = wid_q;
    gap_d = gap_q;
    wc_d  = wc_q;
    lc_d  = lc_q;
    if (arm_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      exp_d = expected_i;
      wid_d = '0;
      gap_d = '0;
      wc_d  = '0;
      lc_d  = '0;
    end else begin
      if (rise && (state_q == WAIT_EDGE || state_q == LOW)) begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        ovf_d = ovf_q | &cnt_q;
        wc_d  = WID_W'(1);
        gap_d = state_q == LOW ? lc_q : gap_q;
      end
      if (state_q == HIGH) begin
        wc_d  = s_q ? (&wc_q ? wc_q : wc_q + 1'b1) : wc_q;
        wid_d = fall ? wc_q : wid_q;
        lc_d  = fall ? WID_W'(1) : lc_q;
      end
      if (state_q == LOW && !rise) lc_d = &lc_q ? lc_q : lc_q + 1'b1;
    end
  end
  // status outputs decoded from the registered state
  always_comb begin
    busy_o = state_q == WAIT_EDGE || state_q == HIGH || state_q == LOW;
    done_o = state_q == DONE;
  end
  assign match_o     = done_o && cnt_q == exp_q && !ovf_q;
  assign overflow_o  = ovf_q;
  assign pulse_cnt_o = cnt_q;
  assign width_o     = wid_q;
  assign gap_o       = gap_q;
endmodule

// File: tb/tb_pulse_train_monitor.sv
// tb_pulse_train_monitor: directed checks of burst counting, measurement, timeout, re-arm and reset
module tb_pulse_train_monitor;
`ifdef PULSE_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0, arm_i = 1'b0;
  logic [7:0] expected_i = '0;
  logic busy_o, done_o, match_o, overflow_o;
  logic [7:0] pulse_cnt_o, width_o, gap_o;
  int n_chk = 0, n_fail = 0;
  pulse_train_monitor #(.CNT_W(8), .WID_W(8), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .pulse_in(pulse_in), .arm_i(arm_i),
    .expected_i(expected_i), .busy_o(busy_o), .done_o(done_o), .match_o(match_o),
    .overflow_o(overflow_o), .pulse_cnt_o(pulse_cnt_o), .width_o(width_o), .gap_o(gap_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      cyc(hi);
      pulse_in = 1'b0;
      cyc(lo);
    end
  endtask
  task automatic arm(input logic [7:0] e);
    expected_i = e;
    arm_i = 1'b1;
    cyc(1);
    arm_i = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!done_o && k < 60) begin
      cyc(1);
      k++;
    end
    check(tag, done_o, 1);
  endtask
  initial begin
    cyc(2);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", pulse_cnt_o, 0);
    rst = 1'b0;
    cyc(2);
    // 1: reset mid-capture
    arm(8'd3);
    check("arm_busy", busy_o, 1);
    pulses(3, 2, 2);
    cyc(3);
    check("t1_cnt", pulse_cnt_o, 3);
    check("t1_width", width_o, 2);
    rst = 1'b1;
    #1;
    check("t1_async_cnt", pulse_cnt_o, 0);
    check("t1_async_busy", busy_o, 0);
    check("t1_async_width", width_o, 0);
    check("t1_async_gap", gap_o, 0);
    cyc(1);
    rst = 1'b0;
    pulses(2, 1, 1);
    cyc(5);
    check("t1_idle_cnt", pulse_cnt_o, 0);
    check("t1_idle_busy", busy_o, 0);
    // 2: five 1/1 pulses, expected 5
    arm(8'd5);
    pulses(5, 1, 1);
    check("t2_not_done", done_o, 0);
    wait_done("t2_done");
    check("t2_cnt", pulse_cnt_o, 5);
    check("t2_width", width_o, 1);
    check("t2_gap", gap_o, 1);
    check("t2_match", match_o, 1);
    check("t2_ovf", overflow_o, 0);
    check("t2_busy", busy_o, 0);
    cyc(5);
    check("t2_hold", done_o, 1);
    // 3: three pulses width 3 gap 7, expected 4
    arm(8'd4);
    check("t3_done_clr", done_o, 0);
    check("t3_cnt_clr", pulse_cnt_o, 0);
    pulses(3, 3, 7);
    wait_done("t3_done");
    check("t3_cnt", pulse_cnt_o, 3);
    check("t3_width", width_o, 3);
    check("t3_gap", gap_o, 7);
    check("t3_match", match_o, 0);
    // 4: counter saturation
    arm(8'd255);
    pulses(300, 1, 1);
    wait_done("t4_done");
    check("t4_cnt", pulse_cnt_o, 255);
    check("t4_ovf", overflow_o, 1);
    check("t4_match", match_o, 0);
    // 5: re-arm during LOW
    arm(8'd9);
    pulses(2, 1, 3);
    check("t5_busy", busy_o, 1);
    check("t5_cnt_pre", pulse_cnt_o, 2);
    arm(8'd1);
    cyc(1);
    check("t5_cnt_clr", pulse_cnt_o, 0);
    check("t5_gap_clr", gap_o, 0);
    check("t5_width_clr", width_o, 0);
    pulses(1, 2, 1);
    wait_done("t5_done");
    check("t5_cnt", pulse_cnt_o, 1);
    check("t5_gap", gap_o, 0);
    check("t5_width", width_o, 2);
    check("t5_match", match_o, 1);
    check("t5_ovf", overflow_o, 0);
    // 6: width saturation and exact timeout boundary
    arm(8'd2);
    pulse_in = 1'b1;
    cyc(300);
    pulse_in = 1'b0;
    cyc(15);
    check("t6_width_sat", width_o, 255);
    check("t6_15_open", done_o, 0);
    pulse_in = 1'b1;
    cyc(1);
    pulse_in = 1'b0;
    cyc(16 + LAT);
    check("t6_16_not_yet", done_o, 0);
    check("t6_gap", gap_o, 15);
    cyc(1);
    check("t6_16_done", done_o, 1);
    check("t6_cnt", pulse_cnt_o, 2);
    check("t6_width", width_o, 1);
    check("t6_match", match_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
